nibble_change_logger: RTL and testbench
=======================================

NIBBLE_CHANGE_LOGGER -- requirements
Module: nibble_change_logger

Interface
REQ-001 Parameter DEPTH, default 4: event FIFO depth, power of two, 2..16.
REQ-002 Parameter TS_W, default 8: timestamp counter width.
REQ-003 Parameter STUCK_LIM, default 16: consecutive no-change sampled cycles that raise stuck.
REQ-004 clk  input  1  single clock; all state on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_val  input  4  nibble from the upstream registered 4-bit output stage.
REQ-007 in_en  input  1  sample qualifier; in_val ignored when low.
REQ-008 clr  input  1  synchronous clear: flush FIFO, zero counters, return to INIT.
REQ-009 ev_valid  output  1  event available at FIFO head.
REQ-010 ev_ready  input  1  consumer accepts head when ev_valid & ev_ready at posedge.
REQ-011 ev_data  output  8+TS_W  {old[3:0], new[3:0], ts[TS_W-1:0]} of head event.
REQ-012 drop_cnt  output  8  saturating count of events dropped because FIFO full.
REQ-013 overflow  output  1  sticky: at least one event dropped.
REQ-014 stuck  output  1  high while stable count >= STUCK_LIM.

Function
REQ-015 Two-state FSM: INIT, ARMED; reset and clr enter INIT.
REQ-016 INIT: first cycle with in_en=1 loads prev<=in_val, moves to ARMED, creates no event.
REQ-017 ARMED: change = in_en & (in_val != prev); on change prev<=in_val, event {prev,in_val,ts} pushed same edge.
REQ-018 ts: free-running TS_W-bit counter, +1 every cycle, wraps 2^TS_W-1 -> 0, zeroed by clr.
REQ-019 Latency: change sampled at edge N -> ev_valid high after edge N if FIFO was empty (show-ahead head).
REQ-020 Pop on ev_valid & ev_ready; ev_data stable while ev_valid & !ev_ready.
REQ-021 Push when full and no pop in same cycle: event dropped, drop_cnt+1 saturating at 255, overflow<=1.
REQ-022 Push and pop same cycle when full: both accepted, occupancy unchanged, no drop.
REQ-023 Push and pop same cycle when occupancy 1: new event becomes head next cycle, ev_valid stays 1.
REQ-024 Stable count: ARMED & in_en & !change -> +1 saturating at STUCK_LIM; change -> 0; in_en=0 -> hold.
REQ-025 clr has priority over push/pop in its cycle; event sampled that cycle is discarded.
REQ-026 ev_ready while ev_valid=0: no effect.

Reset
REQ-027 rst_n low asynchronously forces: state INIT, prev 0, ts 0, FIFO empty, ev_valid 0, ev_data 0, drop_cnt 0, overflow 0, stuck 0, stable count 0.
REQ-028 Reset mid-operation discards all queued events; no event emitted on the first in_en cycle after deassertion.

Structure
REQ-029 Package nibble_log_pkg holds the event struct typedef (old, new, ts), the FSM state enum, and the drop_cnt width constant.
REQ-030 One sub-module nibble_ev_fifo: DEPTH x event, wrap-around pointers plus extra full/empty bit, show-ahead read.
REQ-031 All outputs driven from registers; no combinational path from in_val to any output.

Verification
REQ-032 Reset, in_en=1, in_val 1 for 3 cycles then 3 -> one event old=1 new=3, ts = ts at sampling edge, ev_valid 1 cycle after the change.
REQ-033 ev_ready=0, toggle in_val 0/5 for 6 changes, DEPTH=4 -> 4 events held, drop_cnt=2, overflow=1; drain returns first 4 in order.
REQ-034 FIFO full, ev_ready=1 plus change same cycle -> occupancy stays 4, drop_cnt unchanged.
REQ-035 in_val constant 16 sampled cycles -> stuck=1; one change -> stuck=0 next cycle; in_en=0 for 20 cycles -> stuck held.
REQ-036 Three events queued, assert clr one cycle -> ev_valid 0, drop_cnt 0, overflow 0, next in_en sample makes no event.
REQ-037 rst_n pulsed low mid-burst (asynchronously, between edges) -> all outputs 0 immediately, no events until re-armed.

Source files
------------

// File: rtl/nibble_change_logger_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nibble_log_pkg: shared event, FSM and counter types for the change logger.
// Revision: 1.0
// ----------------------------------------------------------------------------
package nibble_log_pkg;

  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  // Nibble pair of one event; the timestamp is appended below it because its
  // width is a per-instance parameter.
  typedef struct packed {
    logic [3:0] old_nib;
    logic [3:0] new_nib;
  } ev_hdr_t;

  function automatic logic [DROP_W-1:0] sat_inc_drop(input logic [DROP_W-1:0] v);
    return (v == DROP_MAX) ? v : v + DROP_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_change_logger_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nibble_change_logger_if: sample input, event stream and status bundle.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface nibble_change_logger_if #(
  parameter int TS_W = 8
);

  logic [3:0]                        in_val;
  logic                              in_en;
  logic                              clr;
  logic                              ev_valid;
  logic                              ev_ready;
  logic [8+TS_W-1:0]                 ev_data;
  logic [nibble_log_pkg::DROP_W-1:0] drop_cnt;
  logic                              overflow;
  logic                              stuck;

  modport master (
    output in_val, in_en, clr, ev_ready,
    input  ev_valid, ev_data, drop_cnt, overflow, stuck
  );

  modport slave (
    input  in_val, in_en, clr, ev_ready,
    output ev_valid, ev_data, drop_cnt, overflow, stuck
  );

endinterface
`default_nettype wire

// File: rtl/nibble_change_logger_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nibble_ev_fifo: show-ahead event FIFO, wrap-bit pointers, flush has priority.
// Revision: 1.0
// ----------------------------------------------------------------------------
module nibble_ev_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         flush_i,
  input  wire logic         push_i,
  input  wire logic [W-1:0] push_data_i,
  input  wire logic         pop_i,
  output logic              full_o,
  output logic              valid_o,
  output logic [W-1:0]      head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic [W-1:0] mem_q [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_rd_en;
  logic w_wr_en;

  assign w_empty = (wr_q == rd_q);
  assign w_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign w_rd_en = pop_i && !w_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_wr_en = push_i && (!w_full || w_rd_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (w_wr_en) begin
        wr_q <= wr_q + (AW+1)'(1);
      end
      if (w_rd_en) begin
        rd_q <= rd_q + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en && !flush_i) begin
      mem_q[wr_q[AW-1:0]] <= push_data_i;
    end
  end

  assign full_o  = w_full;
  assign valid_o = !w_empty;
  assign head_o  = w_empty ? '0 : mem_q[rd_q[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/nibble_change_logger.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nibble_change_logger: timestamps nibble changes into an event FIFO.
// Revision: 1.0
// ----------------------------------------------------------------------------
module nibble_change_logger
  import nibble_log_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int TS_W      = 8,
  parameter int STUCK_LIM = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  nibble_change_logger_if.slave bus
);

  localparam int EV_W = 8 + TS_W;
  localparam int SW   = $clog2(STUCK_LIM + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STUCK_LIM);

  state_e            state_q, state_d;
  logic [3:0]        prev_q, prev_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [SW-1:0]     stable_q, stable_d;
  logic              stuck_q, stuck_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              ovf_q, ovf_d;

  ev_hdr_t           w_hdr;
  logic [EV_W-1:0]   w_ev;
  logic              w_change;
  logic              w_pop;
  logic              w_drop;
  logic              w_fifo_full;
  logic              w_fifo_valid;
  logic [EV_W-1:0]   w_fifo_head;

  assign w_change = (state_q == ST_ARMED) && bus.in_en && (bus.in_val != prev_q);
  assign w_pop    = w_fifo_valid && bus.ev_ready;
  assign w_drop   = w_change && w_fifo_full && !w_pop;

  assign w_hdr.old_nib = prev_q;
  assign w_hdr.new_nib = bus.in_val;
  assign w_ev          = {w_hdr, ts_q};

  nibble_ev_fifo #(
    .DEPTH (DEPTH),
    .W     (EV_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (bus.clr),
    .push_i      (w_change),
    .push_data_i (w_ev),
    .pop_i       (bus.ev_ready),
    .full_o      (w_fifo_full),
    .valid_o     (w_fifo_valid),
    .head_o      (w_fifo_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      prev_q   <= '0;
      ts_q     <= '0;
      stable_q <= '0;
      stuck_q  <= 1'b0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      ts_q     <= ts_d;
      stable_q <= stable_d;
      stuck_q  <= stuck_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    ts_d     = ts_q;
    stable_d = stable_q;
    stuck_d  = stuck_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;

    if (bus.clr) begin
      state_d  = ST_INIT;
      prev_d   = '0;
      ts_d     = '0;
      stable_d = '0;
      stuck_d  = 1'b0;
      drop_d   = '0;
      ovf_d    = 1'b0;
    end else begin
      ts_d = ts_q + TS_W'(1);

      unique case (state_q)
        ST_INIT: begin
          // The arming sample only establishes a baseline; it never logs.
          if (bus.in_en) begin
            state_d = ST_ARMED;
            prev_d  = bus.in_val;
          end
        end
        ST_ARMED: begin
          if (w_change) begin
            prev_d   = bus.in_val;
            stable_d = '0;
          end else if (bus.in_en && (stable_q != STABLE_MAX)) begin
            stable_d = stable_q + SW'(1);
          end
        end
        default: state_d = ST_INIT;
      endcase

      if (w_drop) begin
        drop_d = sat_inc_drop(drop_q);
        ovf_d  = 1'b1;
      end

      stuck_d = (stable_d >= STABLE_MAX);
    end
  end

  assign bus.ev_valid = w_fifo_valid;
  assign bus.ev_data  = w_fifo_head;
  assign bus.drop_cnt = drop_q;
  assign bus.overflow = ovf_q;
  assign bus.stuck    = stuck_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_change_logger.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_nibble_change_logger: scoreboard bench with a behavioural logger model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_nibble_change_logger;

  localparam int DEPTH     = 4;
  localparam int TS_W      = 8;
  localparam int STUCK_LIM = 16;
  localparam int EW        = 8 + TS_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  nibble_change_logger_if #(.TS_W(TS_W)) bus();

  nibble_change_logger #(
    .DEPTH     (DEPTH),
    .TS_W      (TS_W),
    .STUCK_LIM (STUCK_LIM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural model state
  logic [EW-1:0] exp_q[$];
  int            m_occ;
  int            m_drop;
  int            m_stable;
  int            m_ts;
  bit            m_armed;
  bit            m_ovf;
  logic [3:0]    m_prev;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_occ    = 0;
    m_drop   = 0;
    m_stable = 0;
    m_ts     = 0;
    m_armed  = 0;
    m_ovf    = 0;
    m_prev   = 4'h0;
  endtask

  task automatic model_step(input logic [3:0] v, input logic e, input logic r, input logic c);
    bit pop;
    if (c) begin
      model_reset();
      return;
    end
    pop = (m_occ > 0) && r;
    if (!m_armed) begin
      if (e) begin
        m_armed = 1;
        m_prev  = v;
      end
    end else if (e && (v != m_prev)) begin
      if ((m_occ < DEPTH) || pop) begin
        exp_q.push_back({m_prev, v, TS_W'(m_ts)});
        m_occ++;
      end else begin
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        m_ovf  = 1;
      end
      m_prev   = v;
      m_stable = 0;
    end else if (e) begin
      m_stable = (m_stable < STUCK_LIM) ? m_stable + 1 : STUCK_LIM;
    end
    if (pop) m_occ--;
    m_ts = (m_ts + 1) % (1 << TS_W);
  endtask

  // One clock: drive at posedge+2, model at the edge, check at posedge+1.
  task automatic cyc(input logic [3:0] v, input logic e, input logic r, input logic c);
    bus.in_val   = v;
    bus.in_en    = e;
    bus.ev_ready = r;
    bus.clr      = c;
    @(posedge clk);
    model_step(v, e, r, c);
    #1;
    chk("ev_valid", int'(bus.ev_valid), int'(m_occ > 0));
    chk("drop_cnt", int'(bus.drop_cnt), m_drop);
    chk("overflow", int'(bus.overflow), int'(m_ovf));
    chk("stuck",    int'(bus.stuck),    int'(m_stable >= STUCK_LIM));
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && m_occ > 0; i++) begin
      cyc(m_prev, 1'b0, 1'b1, 1'b0);
    end
    chk("drain_done", int'(bus.ev_valid), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ev_valid"}, int'(bus.ev_valid), 0);
    chk({tag, "_ev_data"},  int'(bus.ev_data),  0);
    chk({tag, "_drop_cnt"}, int'(bus.drop_cnt), 0);
    chk({tag, "_overflow"}, int'(bus.overflow), 0);
    chk({tag, "_stuck"},    int'(bus.stuck),    0);
  endtask

  // Monitor: a handshake visible at the negedge pops at the next posedge.
  always @(negedge clk) begin
    if (rst_n && bus.ev_valid && bus.ev_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL ev_data: got 0x%0h, expected no event at %0t", bus.ev_data, $time);
      end else begin
        chk("ev_data", int'(bus.ev_data), int'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.in_val   = 4'h0;
    bus.in_en    = 1'b0;
    bus.ev_ready = 1'b0;
    bus.clr      = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    #1 rst_n = 1'b1;

    // Single change 1 -> 3 logged with the sampling-edge timestamp
    repeat (3) cyc(4'h1, 1'b1, 1'b0, 1'b0);
    cyc(4'h3, 1'b1, 1'b0, 1'b0);
    chk("first_ev_valid", int'(bus.ev_valid), 1);
    chk("first_ev_data",  int'(bus.ev_data), 16'h1303);
    cyc(4'h3, 1'b1, 1'b0, 1'b0);
    chk("head_stable", int'(bus.ev_data), 16'h1303);
    drain();

    // Six changes into a depth-4 FIFO with no consumer
    for (int i = 0; i < 6; i++) cyc((i % 2 == 0) ? 4'h0 : 4'h5, 1'b1, 1'b0, 1'b0);
    chk("burst_drop_cnt", int'(bus.drop_cnt), 2);
    chk("burst_overflow", int'(bus.overflow), 1);
    drain();

    // Full FIFO: simultaneous pop and push is not a drop
    for (int i = 0; i < 4; i++) cyc((i % 2 == 0) ? 4'h0 : 4'h5, 1'b1, 1'b0, 1'b0);
    cyc(4'h0, 1'b1, 1'b1, 1'b0);
    chk("full_pushpop_drop", int'(bus.drop_cnt), 2);
    chk("full_pushpop_valid", int'(bus.ev_valid), 1);
    drain();

    // Stuck detection, release on change, hold while in_en is low
    repeat (17) cyc(4'h7, 1'b1, 1'b1, 1'b0);
    chk("stuck_set", int'(bus.stuck), 1);
    cyc(4'h8, 1'b1, 1'b1, 1'b0);
    chk("stuck_clear", int'(bus.stuck), 0);
    repeat (16) cyc(4'h8, 1'b1, 1'b1, 1'b0);
    repeat (20) cyc(4'h2, 1'b0, 1'b1, 1'b0);
    chk("stuck_hold", int'(bus.stuck), 1);
    drain();

    // clr with three queued events
    cyc(4'h1, 1'b1, 1'b0, 1'b0);
    cyc(4'h2, 1'b1, 1'b0, 1'b0);
    cyc(4'h3, 1'b1, 1'b0, 1'b0);
    cyc(4'h9, 1'b1, 1'b1, 1'b1);
    check_all_zero("clr");
    cyc(4'h4, 1'b1, 1'b0, 1'b0);
    chk("clr_rearm_no_event", int'(bus.ev_valid), 0);
    drain();

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 6; i++) cyc(4'(i + 5), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(4'h2, 1'b1, 1'b0, 1'b0);
    chk("rst_rearm_no_event", int'(bus.ev_valid), 0);
    cyc(4'h6, 1'b1, 1'b0, 1'b0);
    drain();

    // Drop counter saturation
    for (int i = 0; i < 270; i++) cyc((i % 2 == 0) ? 4'hA : 4'hB, 1'b1, 1'b0, 1'b0);
    chk("drop_saturate", int'(bus.drop_cnt), 255);
    cyc(4'h0, 1'b0, 1'b0, 1'b1);

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      cyc(4'($urandom_range(0, 3)),
          1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 79) == 0));
    end
    drain();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
